// File: rtl/rotate_seq_pkg.sv
// Shared types and default sizes for the
// rotate sequence controller slice.
package rotate_seq_pkg;

  localparam int DEF_WIDTH  = 5;
  localparam int DEF_STEP_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/rotate_sequence_controller_if.sv
// Request/result bundle between a consumer
// and the rotate sequence controller.
interface rotate_sequence_controller_if
  import rotate_seq_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STEP_W = DEF_STEP_W
);

  logic              start;
  logic [WIDTH-1:0]  pattern;
  logic [STEP_W-1:0] steps;
  logic              serial_in;
  logic              abort;
  logic              ack;
  logic [WIDTH-1:0]  q;
  logic              out;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [STEP_W-1:0] remaining;

  modport master (
    output start, pattern, steps,
    output serial_in, abort, ack,
    input  q, out, busy, done,
    input  aborted, remaining
  );

  modport slave (
    input  start, pattern, steps,
    input  serial_in, abort, ack,
    output q, out, busy, done,
    output aborted, remaining
  );

endinterface

// File: rtl/rotate_right_datapath.sv
// Loadable right-rotate register with
// serial_in ORed into the MSB feedback.
module rotate_right_datapath
  import rotate_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic             shift_en,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // load wins over shift; otherwise hold
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (shift_en) begin
      q_d = {q_q[0] | serial_in,
             q_q[WIDTH-1:1]};
    end
  end

  // register with synchronous active-low clear
  always_ff @(posedge clock) begin
    if (!clear) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/rotate_sequence_controller.sv
// Sequencer: load a pattern, rotate it right
// N times (or until abort), hold until ack.
module rotate_sequence_controller
  import rotate_seq_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STEP_W = DEF_STEP_W
) (
  input logic clock,
  input logic clear,
  rotate_sequence_controller_if.slave bus
);

  state_e            state_q;
  state_e            state_d;
  logic [STEP_W-1:0] rem_q;
  logic [STEP_W-1:0] rem_d;
  logic              aborted_q;
  logic              aborted_d;
  logic              load;
  logic              shift_en;
  logic [WIDTH-1:0]  q;

  // next-state, counter and datapath controls
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    aborted_d = aborted_q;
    load      = 1'b0;
    shift_en  = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (bus.start) begin
          load      = 1'b1;
          rem_d     = bus.steps;
          aborted_d = 1'b0;
          state_d   = (bus.steps != '0)
                    ? S_SHIFT : S_DONE;
        end
      end
      (state_q == S_SHIFT): begin
        if (bus.abort) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          shift_en = 1'b1;
          if (rem_q != '0) begin
            rem_d = rem_q - STEP_W'(1);
          end
          if (rem_q <= STEP_W'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      (state_q == S_DONE): begin
        if (bus.ack) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // control state with synchronous clear
  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      aborted_q <= aborted_d;
    end
  end

  rotate_right_datapath #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clock    (clock),
    .clear    (clear),
    .load     (load),
    .shift_en (shift_en),
    .serial_in(bus.serial_in),
    .load_val (bus.pattern),
    .q        (q)
  );

  assign bus.q         = q;
  assign bus.out       = q[0];
  assign bus.busy      = (state_q == S_SHIFT);
  assign bus.done      = (state_q == S_DONE);
  assign bus.aborted   = aborted_q;
  assign bus.remaining = rem_q;

endmodule
